vga_scan_generator: RTL and testbench
=====================================

Name: vga_scan_generator

Overview:
Produces the VGA raster scan that every sprite renderer in the game consumes. It generates row/col pixel coordinates, hsync/vsync, video_on and per-pixel, per-line and per-frame strobes from the board clock. It sits at the top of the display path and drives the sprite blocks, which sample row/col and return pixel bits to the colour mixer. Default timing is 640x480 @ 60 Hz from a 50 MHz clock.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 2, clk cycles per pixel (>=1)
SYNC_ACTIVE, 0, logic level of asserted hsync/vsync

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
row  output  9  visible line index; 9'h1FF outside the visible region
col  output  10  visible pixel index; 10'h3FF outside the visible region
hsync  output  1  horizontal sync, level SYNC_ACTIVE when asserted
vsync  output  1  vertical sync, level SYNC_ACTIVE when asserted
video_on  output  1  1 while (row,col) is visible
pix_tick  output  1  1-clk strobe when a new pixel position is presented
line_start  output  1  1-clk strobe when col becomes 0 (visible line start)
frame_start  output  1  1-clk strobe when position (0,0) is presented

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Internal counters: div (0..CLK_DIV-1), h_cnt (0..H_TOTAL-1), v_cnt (0..V_TOTAL-1). H_TOTAL = sum of H_* (800), V_TOTAL = sum of V_* (525).
- div increments every clk and wraps at CLK_DIV-1. When div==CLK_DIV-1, h_cnt advances. h_cnt wraps H_TOTAL-1 -> 0 and advances v_cnt. v_cnt wraps V_TOTAL-1 -> 0. The wrap from (H_TOTAL-1, V_TOTAL-1) goes to (0,0) in a single step.
- Horizontal phase FSM on h_cnt, mirrored for vertical on v_cnt: VISIBLE [0,H_VISIBLE), FRONT, SYNC, BACK, then VISIBLE. Transitions occur only on advance.
- hsync asserted for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), which is 656..751 at defaults. vsync asserted for v_cnt in 490..491 at defaults. These ranges are independent of video_on.
- All outputs are registered decodes of the counters, 1 clk latency. Each position is held for exactly CLK_DIV clks.
- Outside the visible region, row and col are forced to all-ones so every sprite bounding-box test fails.
- Strobe timing: pix_tick is high on the first clk each new position is presented. line_start = pix_tick & col==0 & row visible. frame_start = pix_tick & position (0,0).
- Reset: div, h_cnt and v_cnt are cleared to 0. While reset is high, outputs are row=1FF, col=3FF, video_on=0, syncs at ~SYNC_ACTIVE, and all strobes 0.
- First clk after reset release: (row,col)=(0,0), video_on=1, pix_tick=line_start=frame_start=1. Position (0,1) follows CLK_DIV clks later.
- Reset mid-frame takes effect on the next edge and restarts the frame at (0,0). No partial sync pulse is extended.
- CLK_DIV=1: pix_tick is constantly 1 outside reset.

Optional Feature:
VGA_FRAME_COUNTER_EN.
- Defined: adds output frame_count (8 bits). It resets to 0, increments by 1 (mod 256) in the same clk that frame_start is asserted, and is not incremented by the first frame_start after reset, so it reads 0 during frame 0. Sprite animators use it in place of free-running cycle counters.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset held 3 clks then released -> during reset row=1FF, col=3FF, video_on=0, hsync=vsync=1. Next clk: row=0, col=0, video_on=1, frame_start=1.
- Defaults, run one line -> col steps 0..639, each held 2 clks. col=3FF for h 640..799. hsync=0 for exactly 192 clks starting 1312 clks after line start. Line period 1600 clks.
- Defaults, run two frames -> frame_start spacing exactly 840000 clks. vsync low for 3200 clks per frame. line_start count per frame = 480.
- Assert reset for 1 clk at row=200, col=300 -> next clk shows reset values, then (0,0) with frame_start=1. No stray hsync/vsync pulse.
- CLK_DIV=1, H_VISIBLE=8, H_FRONT=H_SYNC=H_BACK=2, V_VISIBLE=4, V_FRONT=V_SYNC=V_BACK=1 -> frame period 14*7=98 clks. Wrap goes from last position straight to (0,0).
- With VGA_FRAME_COUNTER_EN -> frame_count is 0 in frame 0, 1 in frame 1, and wraps 255 -> 0 after 256 frames.

Source files
------------

// File: rtl/vga_scan_generator.sv
// vga_scan_generator
//   VGA raster scan source for the display path. Produces visible pixel
//   coordinates, hsync/vsync, video_on and per-pixel / per-line / per-frame
//   strobes. Default timing is 640x480 @ 60 Hz from a 50 MHz clock
//   (CLK_DIV = 2).
//
//   Optional feature macro: VGA_FRAME_COUNTER_EN
//     When defined, an 8-bit frame_count output is added. It reads 0 during
//     the first frame after reset and increments with each later frame_start.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   row   [8:0]  visible line index, all-ones outside the visible region
//   col   [9:0]  visible pixel index, all-ones outside the visible region
//   hsync        horizontal sync, level SYNC_ACTIVE when asserted
//   vsync        vertical sync, level SYNC_ACTIVE when asserted
//   video_on     1 while (row,col) is a visible position
//   pix_tick     1-clk strobe when a new pixel position is presented
//   line_start   1-clk strobe when col becomes 0 on a visible line
//   frame_start  1-clk strobe when position (0,0) is presented
//   frame_count  [7:0] frame number mod 256 (VGA_FRAME_COUNTER_EN only)
//
// Every phase width parameter (H_*, V_*) must be at least 1.

module vga_scan_generator #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned CLK_DIV     = 2,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [8:0] row,
    output logic [9:0] col,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pix_tick,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [7:0] frame_count
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_W   = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned V_W   = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Last index of each horizontal phase
    localparam logic [H_W-1:0] H_VIS_LAST   = H_W'(H_VISIBLE - 1);
    localparam logic [H_W-1:0] H_FRONT_LAST = H_W'(H_VISIBLE + H_FRONT - 1);
    localparam logic [H_W-1:0] H_SYNC_LAST  = H_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [H_W-1:0] H_LAST       = H_W'(H_TOTAL - 1);

    // Last index of each vertical phase
    localparam logic [V_W-1:0] V_VIS_LAST   = V_W'(V_VISIBLE - 1);
    localparam logic [V_W-1:0] V_FRONT_LAST = V_W'(V_VISIBLE + V_FRONT - 1);
    localparam logic [V_W-1:0] V_SYNC_LAST  = V_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [V_W-1:0] V_LAST       = V_W'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        PH_VISIBLE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div,   div_next;
    logic [H_W-1:0]   h_cnt, h_cnt_next;
    logic [V_W-1:0]   v_cnt, v_cnt_next;

    logic h_adv;
    logic h_last;
    logic v_adv;
    logic v_last;

    assign h_adv  = (div == DIV_LAST);
    assign h_last = (h_cnt == H_LAST);
    assign v_adv  = h_adv && h_last;
    assign v_last = (v_cnt == V_LAST);

    always_comb begin
        div_next   = h_adv ? '0 : div + DIV_W'(1);
        h_cnt_next = h_cnt;
        v_cnt_next = v_cnt;
        if (h_adv) begin
            h_cnt_next = h_last ? '0 : h_cnt + H_W'(1);
        end
        if (v_adv) begin
            v_cnt_next = v_last ? '0 : v_cnt + V_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            div   <= div_next;
            h_cnt <= h_cnt_next;
            v_cnt <= v_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Horizontal and vertical phase FSMs
    // Each phase register always describes the current counter value; it
    // moves on the same advance that takes the counter past a phase's
    // last index.
    // ------------------------------------------------------------------
    phase_t h_phase, h_phase_next;
    phase_t v_phase, v_phase_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            h_phase <= PH_VISIBLE;
            v_phase <= PH_VISIBLE;
        end else begin
            h_phase <= h_phase_next;
            v_phase <= v_phase_next;
        end
    end

    always_comb begin
        h_phase_next = h_phase;
        if (h_adv) begin
            case (h_phase)
                PH_VISIBLE: if (h_cnt == H_VIS_LAST)   h_phase_next = PH_FRONT;
                PH_FRONT:   if (h_cnt == H_FRONT_LAST) h_phase_next = PH_SYNC;
                PH_SYNC:    if (h_cnt == H_SYNC_LAST)  h_phase_next = PH_BACK;
                PH_BACK:    if (h_last)                h_phase_next = PH_VISIBLE;
                default:                               h_phase_next = PH_VISIBLE;
            endcase
        end
    end

    always_comb begin
        v_phase_next = v_phase;
        if (v_adv) begin
            case (v_phase)
                PH_VISIBLE: if (v_cnt == V_VIS_LAST)   v_phase_next = PH_FRONT;
                PH_FRONT:   if (v_cnt == V_FRONT_LAST) v_phase_next = PH_SYNC;
                PH_SYNC:    if (v_cnt == V_SYNC_LAST)  v_phase_next = PH_BACK;
                PH_BACK:    if (v_last)                v_phase_next = PH_VISIBLE;
                default:                               v_phase_next = PH_VISIBLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode (registered, one clk behind the counters)
    // ------------------------------------------------------------------
    logic       vis_d;
    logic [8:0] row_d;
    logic [9:0] col_d;
    logic       hsync_d;
    logic       vsync_d;
    logic       pix_d;
    logic       line_d;
    logic       frame_d;

    always_comb begin
        vis_d   = (h_phase == PH_VISIBLE) && (v_phase == PH_VISIBLE);
        // Off-screen coordinates are all-ones so no sprite box can match.
        row_d   = vis_d ? 9'(v_cnt)  : '1;
        col_d   = vis_d ? 10'(h_cnt) : '1;
        hsync_d = (h_phase == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = (v_phase == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        // div==0 is the first clk of each pixel position.
        pix_d   = (div == '0);
        line_d  = pix_d && vis_d && (h_cnt == '0);
        frame_d = pix_d && (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row         <= '1;
            col         <= '1;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            video_on    <= 1'b0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            row         <= row_d;
            col         <= col_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            video_on    <= vis_d;
            pix_tick    <= pix_d;
            line_start  <= line_d;
            frame_start <= frame_d;
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    // ------------------------------------------------------------------
    // Frame counter: the first frame_start after reset only clears the
    // pending flag, so frame 0 reads 0 and frame N reads N mod 256.
    // ------------------------------------------------------------------
    logic first_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
            first_frame <= 1'b1;
        end else if (frame_d) begin
            if (!first_frame) begin
                frame_count <= frame_count + 8'd1;
            end
            first_frame <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_vga_scan_generator.sv
module tb_vga_scan_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned tests    = 0;
    int unsigned failures = 0;

    // ---------------- DUT A: default 640x480 timing ----------------
    logic       rst_a = 1'b1;
    logic [8:0] row_a;
    logic [9:0] col_a;
    logic       hs_a, vs_a, von_a, pt_a, ls_a, fs_a;
`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] fc_a;
`endif

    vga_scan_generator dut_a (
        .clk         (clk),
        .reset       (rst_a),
        .row         (row_a),
        .col         (col_a),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .video_on    (von_a),
        .pix_tick    (pt_a),
        .line_start  (ls_a),
        .frame_start (fs_a)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .frame_count (fc_a)
`endif
    );

    // ---------------- DUT B: tiny 8x4 timing, CLK_DIV=1 ----------------
    logic       rst_b = 1'b1;
    logic [8:0] row_b;
    logic [9:0] col_b;
    logic       hs_b, vs_b, von_b, pt_b, ls_b, fs_b;
`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] fc_b;
`endif

    vga_scan_generator #(
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (2),
        .H_BACK    (2),
        .V_VISIBLE (4),
        .V_FRONT   (1),
        .V_SYNC    (1),
        .V_BACK    (1),
        .CLK_DIV   (1)
    ) dut_b (
        .clk         (clk),
        .reset       (rst_b),
        .row         (row_b),
        .col         (col_b),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .video_on    (von_b),
        .pix_tick    (pt_b),
        .line_start  (ls_b),
        .frame_start (fs_b)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .frame_count (fc_b)
`endif
    );

    logic [24:0] vec_a, vec_b;
    assign vec_a = {row_a, col_a, hs_a, vs_a, von_a, pt_a, ls_a, fs_a};
    assign vec_b = {row_b, col_b, hs_b, vs_b, von_b, pt_b, ls_b, fs_b};

    function automatic logic [24:0] pk(logic [8:0] r, logic [9:0] c,
                                       logic hs, logic vs, logic von,
                                       logic pt, logic ls, logic fs);
        return {r, c, hs, vs, von, pt, ls, fs};
    endfunction

    // Reference: output vector for the c-th clk since (0,0) was first shown.
    function automatic logic [24:0] model(int unsigned c, int unsigned cd,
                                          int unsigned hv, int unsigned hf,
                                          int unsigned hs, int unsigned hb,
                                          int unsigned vv, int unsigned vf,
                                          int unsigned vs, int unsigned vb);
        int unsigned ht, vt, pos, h, v;
        logic von, pt, hsy, vsy;
        logic [8:0] r;
        logic [9:0] cc;
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        pos = c / cd;
        pt  = ((c % cd) == 0);
        h   = pos % ht;
        v   = (pos / ht) % vt;
        von = (h < hv) && (v < vv);
        r   = von ? 9'(v)  : 9'h1FF;
        cc  = von ? 10'(h) : 10'h3FF;
        hsy = !((h >= hv + hf) && (h < hv + hf + hs));
        vsy = !((v >= vv + vf) && (v < vv + vf + vs));
        return pk(r, cc, hsy, vsy, von, pt, pt && von && (h == 0),
                  pt && (h == 0) && (v == 0));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(string name, logic [24:0] act, logic [24:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got row=%h col=%h hs/vs/von/pt/ls/fs=%b, expected row=%h col=%h hs/vs/von/pt/ls/fs=%b",
                     name, act[24:16], act[15:6], act[5:0], exp[24:16], exp[15:6], exp[5:0]);
        end
    endtask

    task automatic check_int(string name, int unsigned act, int unsigned exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int unsigned k;
        string       name;
        logic [24:0] exp;
    } vec_t;

    localparam logic [24:0] RST_VEC = {9'h1FF, 10'h3FF, 6'b110000};

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        int unsigned k;
        int unsigned hs_low, prev_ls, prev_fs, n_fs;
        bit found;

        // k = number of clk edges after reset release
        tbl[0]  = '{1,    "first",    pk(9'd0,   10'd0,   1, 1, 1, 1, 1, 1)};
        tbl[1]  = '{2,    "hold0",    pk(9'd0,   10'd0,   1, 1, 1, 0, 0, 0)};
        tbl[2]  = '{3,    "col1",     pk(9'd0,   10'd1,   1, 1, 1, 1, 0, 0)};
        tbl[3]  = '{1280, "col639",   pk(9'd0,   10'd639, 1, 1, 1, 0, 0, 0)};
        tbl[4]  = '{1281, "hblank",   pk(9'h1FF, 10'h3FF, 1, 1, 0, 1, 0, 0)};
        tbl[5]  = '{1312, "pre_hs",   pk(9'h1FF, 10'h3FF, 1, 1, 0, 0, 0, 0)};
        tbl[6]  = '{1313, "hs_on",    pk(9'h1FF, 10'h3FF, 0, 1, 0, 1, 0, 0)};
        tbl[7]  = '{1504, "hs_last",  pk(9'h1FF, 10'h3FF, 0, 1, 0, 0, 0, 0)};
        tbl[8]  = '{1505, "hs_off",   pk(9'h1FF, 10'h3FF, 1, 1, 0, 1, 0, 0)};
        tbl[9]  = '{1600, "eol",      pk(9'h1FF, 10'h3FF, 1, 1, 0, 0, 0, 0)};
        tbl[10] = '{1601, "line1",    pk(9'd1,   10'd0,   1, 1, 1, 1, 1, 0)};
        tbl[11] = '{1603, "line1c1",  pk(9'd1,   10'd1,   1, 1, 1, 1, 0, 0)};

        // ---- DUT A: reset held 3 clks ----
        rst_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_vec("a_reset_hold", vec_a, RST_VEC);
        end
`ifdef VGA_FRAME_COUNTER_EN
        check_int("a_fc_reset", fc_a, 0);
`endif
        rst_a = 1'b0;

        // ---- DUT A: table of directed points on the first two lines ----
        k = 0;
        for (int i = 0; i < 12; i++) begin
            while (k < tbl[i].k) begin
                step();
                k++;
            end
            check_vec(tbl[i].name, vec_a, tbl[i].exp);
        end

        // ---- DUT A: two full lines against the reference ----
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        hs_low  = 0;
        prev_ls = 0;
        for (int unsigned c = 0; c < 3200; c++) begin
            step();
            check_vec("a_sweep", vec_a, model(c, 2, 640, 16, 96, 48, 480, 10, 2, 33));
            if (c < 1600 && !hs_a) hs_low++;
            if (ls_a && c > 0) begin
                check_int("a_line_period", c - prev_ls, 1600);
                prev_ls = c;
            end
        end
        check_int("a_hsync_low_clks", hs_low, 192);

        // ---- DUT B: three frames, CLK_DIV=1 ----
        step();
        rst_b = 1'b0;
        prev_fs = 0;
        n_fs    = 0;
        for (int unsigned c = 0; c < 294; c++) begin
            step();
            check_vec("b_sweep", vec_b, model(c, 1, 8, 2, 2, 2, 4, 1, 1, 1));
            check_int("b_pix_tick", pt_b, 1);
            if (c == 97) check_vec("b_last_pos", vec_b, pk(9'h1FF, 10'h3FF, 1, 1, 0, 1, 0, 0));
            if (c == 98) check_vec("b_wrap", vec_b, pk(9'd0, 10'd0, 1, 1, 1, 1, 1, 1));
            if (fs_b) begin
                if (n_fs > 0) check_int("b_frame_period", c - prev_fs, 98);
                prev_fs = c;
                n_fs++;
            end
        end
        check_int("b_frame_count_seen", n_fs, 3);

        // ---- DUT B: reset for one clk at (2,3) ----
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (row_b == 9'd2 && col_b == 10'd3) found = 1'b1;
            else step();
        end
        check_int("b_mid_search", found, 1);
        rst_b = 1'b1;
        step();
        check_vec("b_mid_reset", vec_b, RST_VEC);
        rst_b = 1'b0;
        step();
        check_vec("b_mid_restart", vec_b, pk(9'd0, 10'd0, 1, 1, 1, 1, 1, 1));
        for (int unsigned c = 1; c < 98; c++) begin
            step();
            check_vec("b_after_reset", vec_b, model(c, 1, 8, 2, 2, 2, 4, 1, 1, 1));
        end

`ifdef VGA_FRAME_COUNTER_EN
        // ---- DUT B: frame counter over 257 frames ----
        rst_b = 1'b1;
        step();
        check_int("b_fc_reset", fc_b, 0);
        rst_b = 1'b0;
        for (int unsigned c = 0; c <= 257 * 98; c++) begin
            step();
            if ((c % 98) == 0 || (c % 98) == 50 || (c % 98) == 97)
                check_int("b_frame_count", fc_b, (c / 98) % 256);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
